// File: rtl/frogger_pkg.sv
// Shared Frogger definitions: screen geometry, HID keycodes and frog FSM encoding.
// Used by the frog controller and by the lilypad/car movers.
package frogger_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int TILE     = 40;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    localparam logic [2:0] ST_ALIVE     = 3'd0;
    localparam logic [2:0] ST_COOLDOWN  = 3'd1;
    localparam logic [2:0] ST_DYING     = 3'd2;
    localparam logic [2:0] ST_RESPAWN   = 3'd3;
    localparam logic [2:0] ST_GAME_OVER = 3'd4;

    typedef enum logic [2:0] {
        ALIVE     = ST_ALIVE,
        COOLDOWN  = ST_COOLDOWN,
        DYING     = ST_DYING,
        RESPAWN   = ST_RESPAWN,
        GAME_OVER = ST_GAME_OVER
    } frog_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/frog_key_decoder.sv
// Turns the raw HID keycode into single-frame hop pulses; a held key fires only once
// because a pulse needs the keycode to differ from the previous frame's.
module frog_key_decoder
    import frogger_pkg::*;
(
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic       hop_up,
    output logic       hop_down,
    output logic       hop_left,
    output logic       hop_right
);

    logic [7:0] prev_key_q;
    logic [7:0] prev_key_d;
    logic       key_edge;

    always_comb begin
        prev_key_d = keycode;
        key_edge   = (keycode != prev_key_q);
        hop_up     = key_edge && (keycode == KEY_W);
        hop_down   = key_edge && (keycode == KEY_S);
        hop_left   = key_edge && (keycode == KEY_A);
        hop_right  = key_edge && (keycode == KEY_D);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            prev_key_q <= '0;
        end else begin
            prev_key_q <= prev_key_d;
        end
    end

endmodule

// File: rtl/frog_controller.sv
// Frog FSM: hops, riding lilypads, drowning/car deaths, respawn, lives and score.
// All outputs are registered; every action lands on the frame_clk edge after sampling.
//
//   state     | meaning
//   ALIVE     | accepts hops, rides pads, can drown or be hit
//   COOLDOWN  | just hopped; keys ignored, drowning suppressed, still rides and can be hit
//   DYING     | Frog_Dead high for DEATH_FRAMES frames
//   RESPAWN   | one frame; frog returns to the start tile
//   GAME_OVER | no lives left; frozen until Reset
module frog_controller
    import frogger_pkg::*;
#(
    parameter logic [10:0] X_START      = 11'd320,
    parameter logic [10:0] Y_START      = 11'd440,
    parameter logic [10:0] STEP         = 11'd40,
    parameter logic [10:0] X_MAX        = 11'd600,
    parameter logic [10:0] WATER_TOP    = 11'd40,
    parameter logic [10:0] WATER_BOT    = 11'd200,
    parameter logic [4:0]  HOP_COOLDOWN = 5'd8,
    parameter logic [6:0]  DEATH_FRAMES = 7'd60,
    parameter logic [1:0]  LIVES        = 2'd3
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [7:0]  keycode,
    input  logic        Pad_Collision,
    input  logic        Pad_Dir,
    input  logic        Pad_Step,
    input  logic        Car_Collision,
    output logic [10:0] Frog_X,
    output logic [10:0] Frog_Y,
    output logic [1:0]  Lives,
    output logic [7:0]  Score,
    output logic        Frog_Dead,
    output logic        Game_Over
);

    logic hop_up, hop_down, hop_left, hop_right;

    frog_key_decoder u_key_decoder (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .hop_up    (hop_up),
        .hop_down  (hop_down),
        .hop_left  (hop_left),
        .hop_right (hop_right)
    );

    frog_state_t state_q, state_d;
    logic [10:0] x_q, x_d, y_q, y_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  score_q, score_d;
    logic [4:0]  cool_cnt_q, cool_cnt_d;
    logic [6:0]  death_cnt_q, death_cnt_d;
    logic        frog_dead_q, frog_dead_d;
    logic        game_over_q, game_over_d;

    logic [11:0] x_ext, y_ext, step_ext;
    logic [10:0] hop_x, hop_y, ride_x;
    logic        in_water, hop_legal, hop_fire, ride_req, ride_off, drown, die;

    // Bound checks and candidate positions; sums are widened so nothing wraps.
    always_comb begin
        x_ext     = {1'b0, x_q};
        y_ext     = {1'b0, y_q};
        step_ext  = {1'b0, STEP};
        in_water  = (y_q >= WATER_TOP) && (y_q <= WATER_BOT);
        hop_legal = 1'b0;
        hop_x     = x_q;
        hop_y     = y_q;
        if (hop_up && (y_q >= STEP)) begin
            hop_legal = 1'b1;
            hop_y     = y_q - STEP;
        end else if (hop_down && ((y_ext + step_ext) <= {1'b0, Y_START})) begin
            hop_legal = 1'b1;
            hop_y     = y_q + STEP;
        end else if (hop_left && (x_q >= STEP)) begin
            hop_legal = 1'b1;
            hop_x     = x_q - STEP;
        end else if (hop_right && ((x_ext + step_ext) <= {1'b0, X_MAX})) begin
            hop_legal = 1'b1;
            hop_x     = x_q + STEP;
        end
        ride_req = in_water && Pad_Collision && Pad_Step;
        ride_off = Pad_Dir ? ((x_ext + step_ext) > {1'b0, X_MAX}) : (x_q < STEP);
        ride_x   = Pad_Dir ? (x_q + STEP) : (x_q - STEP);
        hop_fire = (state_q == ALIVE) && hop_legal;
        drown    = (state_q == ALIVE) && in_water && !Pad_Collision;
        // A hop in the same frame drops the ride, so a dropped ride cannot kill.
        die      = Car_Collision || drown || (ride_req && ride_off && !hop_fire);
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        lives_d     = lives_q;
        score_d     = score_q;
        cool_cnt_d  = cool_cnt_q;
        death_cnt_d = death_cnt_q;
        case (state_q)
            ALIVE, COOLDOWN: begin
                if (die) begin
                    state_d     = DYING;
                    death_cnt_d = DEATH_FRAMES;
                    lives_d     = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                end else if (hop_fire) begin
                    x_d = hop_x;
                    y_d = hop_y;
                    if (hop_y == 11'd0) begin
                        state_d = RESPAWN;
                        score_d = sat_inc8(score_q);
                    end else begin
                        state_d    = COOLDOWN;
                        cool_cnt_d = HOP_COOLDOWN;
                    end
                end else begin
                    if (ride_req) begin
                        x_d = ride_x;
                    end
                    if (state_q == COOLDOWN) begin
                        if (cool_cnt_q == 5'd1) begin
                            state_d    = ALIVE;
                            cool_cnt_d = 5'd0;
                        end else begin
                            cool_cnt_d = cool_cnt_q - 5'd1;
                        end
                    end
                end
            end
            DYING: begin
                if (death_cnt_q == 7'd1) begin
                    state_d     = (lives_q == 2'd0) ? GAME_OVER : RESPAWN;
                    death_cnt_d = 7'd0;
                end else begin
                    death_cnt_d = death_cnt_q - 7'd1;
                end
            end
            RESPAWN: begin
                x_d     = X_START;
                y_d     = Y_START;
                state_d = ALIVE;
            end
            GAME_OVER: begin
                state_d = GAME_OVER;
            end
            default: begin
                state_d = ALIVE;
            end
        endcase
        frog_dead_d = (state_d == DYING);
        game_over_d = (state_d == GAME_OVER);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ALIVE;
            x_q         <= X_START;
            y_q         <= Y_START;
            lives_q     <= LIVES;
            score_q     <= '0;
            cool_cnt_q  <= '0;
            death_cnt_q <= '0;
            frog_dead_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            cool_cnt_q  <= cool_cnt_d;
            death_cnt_q <= death_cnt_d;
            frog_dead_q <= frog_dead_d;
            game_over_q <= game_over_d;
        end
    end

    assign Frog_X    = x_q;
    assign Frog_Y    = y_q;
    assign Lives     = lives_q;
    assign Score     = score_q;
    assign Frog_Dead = frog_dead_q;
    assign Game_Over = game_over_q;

endmodule

// File: tb/tb_frog_controller.sv
// Directed bench for frog_controller: hops, bounds, riding, drowning, car deaths,
// game over, reaching home and reset during DYING.
module tb_frog_controller;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic [7:0]  keycode;
    logic        Pad_Collision, Pad_Dir, Pad_Step, Car_Collision;
    logic [10:0] Frog_X, Frog_Y;
    logic [1:0]  Lives;
    logic [7:0]  Score;
    logic        Frog_Dead, Game_Over;

    int errors = 0;
    int checks = 0;

    frog_controller dut (
        .frame_clk     (frame_clk),
        .Reset         (Reset),
        .keycode       (keycode),
        .Pad_Collision (Pad_Collision),
        .Pad_Dir       (Pad_Dir),
        .Pad_Step      (Pad_Step),
        .Car_Collision (Car_Collision),
        .Frog_X        (Frog_X),
        .Frog_Y        (Frog_Y),
        .Lives         (Lives),
        .Score         (Score),
        .Frog_Dead     (Frog_Dead),
        .Game_Over     (Game_Over)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One-frame keypress, then release and sit out the cooldown.
    task automatic press(input logic [7:0] k);
        keycode = k;
        tick();
        keycode = 8'h00;
        ticks(8);
    endtask

    task automatic do_reset();
        keycode       = 8'h00;
        Pad_Collision = 1'b0;
        Pad_Dir       = 1'b0;
        Pad_Step      = 1'b0;
        Car_Collision = 1'b0;
        Reset         = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_x", 32'(Frog_X), 320);
        chk("rst_y", 32'(Frog_Y), 440);
        chk("rst_lives", 32'(Lives), 3);
        chk("rst_score", 32'(Score), 0);
        chk("rst_dead", 32'(Frog_Dead), 0);
        chk("rst_go", 32'(Game_Over), 0);

        // Held W hops once; keys ignored for 8 cooldown frames.
        keycode = 8'h1A;
        tick();
        chk("hop_up_y", 32'(Frog_Y), 400);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("held_no_repeat", 32'(Frog_Y), 400);
        end
        keycode = 8'h00;
        ticks(3);
        keycode = 8'h16;
        tick();
        chk("cooldown_last_frame_ignored", 32'(Frog_Y), 400);
        keycode = 8'h07;
        tick();
        chk("first_alive_hop_right", 32'(Frog_X), 360);
        keycode = 8'h00;
        ticks(8);

        // Screen bounds.
        do_reset();
        keycode = 8'h16;
        tick();
        chk("down_at_bottom", 32'(Frog_Y), 440);
        keycode = 8'h00;
        tick();
        for (int i = 0; i < 8; i++) press(8'h04);
        chk("left_to_zero", 32'(Frog_X), 0);
        keycode = 8'h04;
        tick();
        chk("left_at_zero", 32'(Frog_X), 0);
        keycode = 8'h00;
        tick();
        keycode = 8'h07;
        tick();
        chk("no_cooldown_after_blocked", 32'(Frog_X), 40);
        keycode = 8'h00;
        ticks(8);
        for (int i = 0; i < 14; i++) press(8'h07);
        chk("right_to_max", 32'(Frog_X), 600);
        keycode = 8'h07;
        tick();
        chk("right_at_max", 32'(Frog_X), 600);
        keycode = 8'h00;
        tick();
        keycode = 8'h04;
        tick();
        chk("alive_after_blocked_right", 32'(Frog_X), 560);
        keycode = 8'h00;
        ticks(8);

        // Riding a right-moving pad until it carries the frog off the edge.
        do_reset();
        Pad_Collision = 1'b1;
        for (int i = 0; i < 6; i++) press(8'h1A);
        chk("reach_water_y", 32'(Frog_Y), 200);
        Pad_Dir  = 1'b0;
        Pad_Step = 1'b1;
        keycode  = 8'h07;
        tick();
        chk("hop_beats_ride", 32'(Frog_X), 360);
        Pad_Step = 1'b0;
        keycode  = 8'h00;
        ticks(8);
        Pad_Dir = 1'b1;
        for (int i = 0; i < 6; i++) begin
            Pad_Step = 1'b1;
            tick();
            Pad_Step = 1'b0;
            chk("ride_right_x", 32'(Frog_X), 32'(400 + 40 * i));
            tick();
        end
        Pad_Step = 1'b1;
        tick();
        Pad_Step = 1'b0;
        chk("ride_off_dead", 32'(Frog_Dead), 1);
        chk("ride_off_lives", 32'(Lives), 2);
        chk("ride_off_x_held", 32'(Frog_X), 600);

        // Drowning is suppressed during cooldown.
        do_reset();
        for (int i = 0; i < 5; i++) press(8'h1A);
        keycode = 8'h1A;
        tick();
        keycode = 8'h00;
        chk("drown_hop_y", 32'(Frog_Y), 200);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("no_drown_in_cooldown", 32'(Frog_Dead), 0);
        end
        tick();
        chk("drown_first_alive", 32'(Frog_Dead), 1);
        chk("drown_lives", 32'(Lives), 2);

        // Three car hits lead to game over.
        do_reset();
        press(8'h1A);
        Car_Collision = 1'b1;
        tick();
        Car_Collision = 1'b0;
        chk("car1_dead", 32'(Frog_Dead), 1);
        chk("car1_lives", 32'(Lives), 2);
        ticks(59);
        chk("dying_frame_60", 32'(Frog_Dead), 1);
        tick();
        chk("dying_over", 32'(Frog_Dead), 0);
        tick();
        chk("respawn_y", 32'(Frog_Y), 440);
        Car_Collision = 1'b1;
        tick();
        Car_Collision = 1'b0;
        chk("car2_lives", 32'(Lives), 1);
        ticks(61);
        Car_Collision = 1'b1;
        tick();
        Car_Collision = 1'b0;
        chk("car3_lives", 32'(Lives), 0);
        ticks(59);
        chk("go_not_yet", 32'(Game_Over), 0);
        tick();
        chk("game_over", 32'(Game_Over), 1);
        chk("go_not_dead", 32'(Frog_Dead), 0);
        keycode = 8'h1A;
        tick();
        keycode = 8'h00;
        tick();
        chk("go_keys_ignored", 32'(Frog_Y), 440);
        Car_Collision = 1'b1;
        tick();
        Car_Collision = 1'b0;
        chk("go_lives_hold", 32'(Lives), 0);
        chk("go_hold", 32'(Game_Over), 1);

        // Reaching home, then reset in the middle of DYING.
        do_reset();
        Pad_Collision = 1'b1;
        for (int i = 0; i < 10; i++) press(8'h1A);
        chk("top_water_row", 32'(Frog_Y), 40);
        keycode = 8'h1A;
        tick();
        keycode = 8'h00;
        chk("home_score", 32'(Score), 1);
        chk("home_lives", 32'(Lives), 3);
        tick();
        chk("home_respawn_x", 32'(Frog_X), 320);
        chk("home_respawn_y", 32'(Frog_Y), 440);
        press(8'h1A);
        Car_Collision = 1'b1;
        tick();
        Car_Collision = 1'b0;
        ticks(10);
        chk("mid_dying", 32'(Frog_Dead), 1);
        Reset = 1'b1;
        #1;
        chk("rst2_x", 32'(Frog_X), 320);
        chk("rst2_y", 32'(Frog_Y), 440);
        chk("rst2_lives", 32'(Lives), 3);
        chk("rst2_score", 32'(Score), 0);
        chk("rst2_dead", 32'(Frog_Dead), 0);
        chk("rst2_go", 32'(Game_Over), 0);
        tick();
        Reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
